x_multdiv_unit: RTL and testbench
=================================

// Module: x_multdiv_unit
// PURPOSE
//   Execute-stage iterative signed multiply/divide unit. Consumes the operands and
//   destination tag leaving the D/X pipeline latch, and computes one result bit per
//   cycle. Raises stall to freeze the upstream latches while it is busy, then presents
//   a registered result, exception flag and tag to the X/M latch.
// PARAMETERS
//   WIDTH     32   operand/result width; iteration count = WIDTH
//   TAG_W     5    destination-register tag width
// PORTS
//   clock           in   1       system clock, rising edge
//   reset           in   1       synchronous, active-high
//   operandA        in   WIDTH   multiplicand / dividend (two's complement)
//   operandB        in   WIDTH   multiplier / divisor (two's complement)
//   ctrl_MULT       in   1       start-multiply request, sampled each cycle
//   ctrl_DIV        in   1       start-divide request, sampled each cycle
//   rd_in           in   TAG_W   destination tag, captured with operands at start
//   stall           out  1       freeze request to PC, F/D and D/X latches
//   data_result     out  WIDTH   registered result, held until next accepted start
//   data_exception  out  1       overflow / divide-by-zero, qualified by data_resultRDY
//   data_resultRDY  out  1       single-cycle completion pulse
//   rd_out          out  TAG_W   tag of the completing operation
// BEHAVIOUR
//   - Reset: state=IDLE, count=0; data_result=0, data_exception=0, data_resultRDY=0,
//     rd_out=0, stall=0. Reset takes effect even mid-operation: the op is dropped, no
//     RDY pulse is issued, and a new start is accepted in the first cycle after reset.
//   - States: IDLE, MULT, DIV, DONE.
//       IDLE/DONE --ctrl_MULT--> MULT;  IDLE/DONE --ctrl_DIV--> DIV;  otherwise -> IDLE.
//       MULT/DIV: count increments by 1 per cycle; at count==WIDTH-1 -> DONE.
//   - Start acceptance: only in IDLE or DONE. Requests in MULT/DIV are ignored; there is
//     no queueing. ctrl_MULT and ctrl_DIV both high: multiply wins.
//   - On accept: operandA, operandB and rd_in are captured. Later input changes have no
//     effect on the op in flight.
//   - Timing, with the start sampled in cycle c0:
//       c1..cWIDTH   compute (WIDTH cycles)
//       c(WIDTH+1)   DONE: data_resultRDY=1 for exactly one cycle, outputs valid
//     data_result, data_exception and rd_out stay stable after DONE until the next
//     accepted start.
//   - stall = (start accepted this cycle, combinational) | (state is MULT or DIV).
//     stall is high in c0..cWIDTH (WIDTH+1 cycles) and low in c(WIDTH+1).
//   - Multiply: signed. Iterative shift-add on operand magnitudes; the 2*WIDTH product
//     is sign-corrected at the end. data_result = low WIDTH bits of the product.
//     data_exception=1 iff the full product is not representable in WIDTH-bit signed.
//   - Divide: signed, quotient truncated toward zero; the remainder is discarded.
//     Restoring division on magnitudes; quotient negated when the operand signs differ.
//     Divisor==0: data_result=0, data_exception=1, latency unchanged.
//     MIN_INT / -1: data_result=MIN_INT (0x80000000), data_exception=1.
//   - Latency is fixed at WIDTH+1 cycles from start to RDY for every case, including
//     exceptions and zero operands.
//   - Back-to-back: a start sampled in the DONE cycle is accepted. RDY still pulses in
//     that cycle for the old op, and stall rises in the same cycle for the new op.
// TESTING
//   1. MULT 7 x -3 (0xFFFFFFFD), rd_in=5 -> stall high 33 cycles, RDY at c33,
//      result 0xFFFFFFEB, exc=0, rd_out=5.
//   2. MULT 0x00010000 x 0x00010000 -> result 0x00000000, exc=1;
//      MULT 0x7FFFFFFF x 1 -> result 0x7FFFFFFF, exc=0.
//   3. DIV -7/2 -> 0xFFFFFFFD, exc=0; DIV 5/0 -> result 0, exc=1, RDY still at c33;
//      DIV 0x80000000/-1 -> 0x80000000, exc=1.
//   4. Start DIV 100/7, then pulse ctrl_MULT at c5 with other operands -> ignored;
//      RDY at c33 with result 14; no second RDY pulse.
//   5. Start MULT, assert reset at c10 -> all outputs 0 next cycle, no RDY pulse;
//      MULT 3x4 issued right after reset -> result 12 after 33 cycles.
//   6. ctrl_MULT and ctrl_DIV both high with 6,3 -> result 18 (multiply). New start in
//      the DONE cycle -> old RDY pulses, stall stays high, second result correct.

Source files
------------

// File: rtl/x_multdiv_unit.sv
// Iterative signed multiply/divide for the execute stage: one result bit per cycle,
// stalls the front of the pipe while busy and hands a registered result to X/M.
module x_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [TAG_W-1:0] rd_in,
  output logic             stall,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAG_W-1:0] rd_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] mcand_q, prod_q;
  logic [WIDTH-1:0]   mplier_q, rem_q, quo_q, dvs_q;
  logic               neg_q, dz_q, dovf_q;
  logic [TAG_W-1:0]   tag_q, rd_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q, rdy_q;

  logic               start_s, busy_s, last_s;
  logic [2*WIDTH-1:0] mul_sum_s, mul_res_s;
  logic               mul_exc_s, div_ge_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH-1:0]   rem_sub_s, quo_nx_s, quo_sgn_s, fin_res_s;
  logic               fin_exc_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start_s = ((state_q == S_IDLE) || (state_q == S_DONE)) && (ctrl_MULT || ctrl_DIV);
  assign busy_s  = (state_q == S_MULT) || (state_q == S_DIV);
  assign last_s  = busy_s && (count_q == CNT_LAST);
  assign stall   = start_s || busy_s;

  // One shift-add step and one restoring-divide step, plus the sign fix-up of each.
  assign mul_sum_s = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign mul_res_s = neg_q ? -mul_sum_s : mul_sum_s;
  assign mul_exc_s = !((&mul_res_s[2*WIDTH-1:WIDTH-1]) || !(|mul_res_s[2*WIDTH-1:WIDTH-1]));
  assign rem_sh_s  = {rem_q, quo_q[WIDTH-1]};
  assign div_ge_s  = rem_sh_s >= {1'b0, dvs_q};
  assign rem_sub_s = rem_sh_s[WIDTH-1:0] - dvs_q;
  assign quo_nx_s  = {quo_q[WIDTH-2:0], div_ge_s};
  assign quo_sgn_s = neg_q ? -quo_nx_s : quo_nx_s;

  // Final result value for the op completing this cycle.
  always_comb begin
    fin_res_s = result_q;
    fin_exc_s = exc_q;
    case (state_q)
      S_MULT: begin
        fin_res_s = mul_res_s[WIDTH-1:0];
        fin_exc_s = mul_exc_s;
      end
      S_DIV: begin
        if (dz_q) begin
          fin_res_s = {WIDTH{1'b0}};
          fin_exc_s = 1'b1;
        end else begin
          fin_res_s = quo_sgn_s;
          fin_exc_s = dovf_q;
        end
      end
      default: begin
        fin_res_s = result_q;
        fin_exc_s = exc_q;
      end
    endcase
  end

  // Next-state logic; multiply wins when both requests are raised.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        count_d = {CNT_W{1'b0}};
        if (ctrl_MULT)     state_d = S_MULT;
        else if (ctrl_DIV) state_d = S_DIV;
        else               state_d = S_IDLE;
      end
      S_MULT, S_DIV: begin
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) state_d = S_DONE;
        else                     state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
        count_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= {CNT_W{1'b0}};
      rdy_q    <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      exc_q    <= 1'b0;
      rd_q     <= {TAG_W{1'b0}};
      tag_q    <= {TAG_W{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdy_q   <= last_s;
      if (last_s) begin
        result_q <= fin_res_s;
        exc_q    <= fin_exc_s;
        rd_q     <= tag_q;
      end
      if (start_s) tag_q <= rd_in;
    end
  end

  // Operand capture and iteration datapath, working on magnitudes.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      dovf_q   <= 1'b0;
    end else if (start_s) begin
      neg_q <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
      if (ctrl_MULT) begin
        mcand_q  <= {{WIDTH{1'b0}}, mag(operandA)};
        mplier_q <= mag(operandB);
        prod_q   <= {(2*WIDTH){1'b0}};
        dz_q     <= 1'b0;
        dovf_q   <= 1'b0;
      end else begin
        quo_q  <= mag(operandA);
        rem_q  <= {WIDTH{1'b0}};
        dvs_q  <= mag(operandB);
        dz_q   <= (operandB == {WIDTH{1'b0}});
        dovf_q <= (operandA == MIN_INT) && (operandB == {WIDTH{1'b1}});
      end
    end else if (state_q == S_MULT) begin
      prod_q   <= mul_sum_s;
      mcand_q  <= mcand_q << 1'b1;
      mplier_q <= mplier_q >> 1'b1;
    end else if (state_q == S_DIV) begin
      rem_q <= div_ge_s ? rem_sub_s : rem_sh_s[WIDTH-1:0];
      quo_q <= quo_nx_s;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign rd_out         = rd_q;

endmodule

// File: tb/tb_x_multdiv_unit.sv
// Directed and randomized checks of x_multdiv_unit against an arithmetic reference.
module tb_x_multdiv_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] operandA, operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [4:0]  rd_in;
  logic        stall;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_r;
  logic        last_e;
  logic [4:0]  last_t;

  x_multdiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .operandA(operandA), .operandB(operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .rd_in(rd_in), .stall(stall),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .rd_out(rd_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (m) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (sb == 0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (sa == -32'sd2147483647 - 32'sd1 && sb == -32'sd1) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      r = 32'(sa / sb);
      e = 1'b0;
    end
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, 64'(data_result), 64'h0);
    chk({tag, "_exc"},    64'(data_exception), 64'h0);
    chk({tag, "_rdy"},    64'(data_resultRDY), 64'h0);
    chk({tag, "_rd"},     64'(rd_out), 64'h0);
    chk({tag, "_stall"},  64'(stall), 64'h0);
  endtask

  // Issue an op from a negedge; returns at the negedge of its RDY cycle.
  // A nonzero inj pulses a spurious ctrl_MULT in cycle inj of the computation.
  task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input int inj);
    bit got;
    model(m, a, b, last_r, last_e);
    last_t = tag;
    operandA = a; operandB = b; ctrl_MULT = m; ctrl_DIV = d; rd_in = tag;
    #1 chk("stall_c0", 64'(stall), 64'h1);
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1 || k == inj + 1) begin
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        operandA = $urandom; operandB = $urandom; rd_in = 5'($urandom);
      end
      if (inj != 0 && k == inj) begin
        ctrl_MULT = 1'b1; operandA = 32'd9; operandB = 32'd9;
      end
      if (data_resultRDY) begin
        got = 1'b1;
        chk("latency", 64'(k), 64'd33);
        chk("result", 64'(data_result), 64'(last_r));
        chk("exc", 64'(data_exception), 64'(last_e));
        chk("rd_out", 64'(rd_out), 64'(last_t));
        chk("stall_done", 64'(stall), 64'h0);
        break;
      end
      chk("stall_busy", 64'(stall), 64'h1);
    end
    if (!got) chk("rdy_timeout", 64'h0, 64'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      chk("rdy_single", 64'(data_resultRDY), 64'h0);
      chk("stall_idle", 64'(stall), 64'h0);
      chk("hold_result", 64'(data_result), 64'(last_r));
      chk("hold_exc", 64'(data_exception), 64'(last_e));
      chk("hold_rd", 64'(rd_out), 64'(last_t));
    end
  endtask

  initial begin
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    operandA = 32'h0; operandB = 32'h0; rd_in = 5'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    run(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 5'd5, 0);
    chk("mul_7x-3_const", 64'(data_result), 64'hFFFFFFEB);
    idle(2);
    run(1'b1, 1'b0, 32'h00010000, 32'h00010000, 5'd1, 0); idle(1);
    run(1'b1, 1'b0, 32'h7FFFFFFF, 32'd1, 5'd2, 0);        idle(1);
    run(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd3, 0);        idle(1);
    run(1'b0, 1'b1, 32'd5, 32'd0, 5'd4, 0);               idle(1);
    run(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd6, 0); idle(1);
    run(1'b0, 1'b1, 32'd100, 32'd7, 5'd7, 5);
    chk("div_100_7_const", 64'(data_result), 64'd14);
    idle(5);

    // Reset in the middle of a multiply drops it without a RDY pulse.
    operandA = 32'd123; operandB = 32'd456; ctrl_MULT = 1'b1; rd_in = 5'd9;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("midop_reset");
    reset = 1'b0;
    run(1'b1, 1'b0, 32'd3, 32'd4, 5'd10, 0); idle(1);

    // Both requests high, then a start in the DONE cycle.
    run(1'b1, 1'b1, 32'd6, 32'd3, 5'd11, 0);
    chk("both_high_mul", 64'(data_result), 64'd18);
    run(1'b0, 1'b1, 32'hFFFFFF9C, 32'd9, 5'd12, 0);
    idle(2);

    for (int i = 0; i < 14; i++) begin
      logic m;
      logic [31:0] a, b;
      m = 1'($urandom);
      a = ($urandom_range(0, 2) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($signed(8'($urandom)))  : $urandom;
      if (i == 3) b = 32'h0;
      if (i == 5) a = 32'h80000000;
      run(m, ~m, a, b, 5'($urandom), 0);
      if (i % 2 == 1) idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
